logical_rs: RTL and testbench

//  Reservation station for the logical/shift functional unit in the OoO backend.

---
 rtl/logical_rs_if.sv | 55 +++++
 rtl/logical_rs.sv | 203 ++++++++++++++++++++
 tb/tb_logical_rs.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logical_rs_if.sv
// Dispatch / CDB / issue bundle for the logical-unit reservation station.
// master = rename/dispatch side plus CDB driver, slave = the station itself.
interface logical_rs_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TW   = 8
);
    logic            flush;

    logic            disp_valid;
    logic            disp_ready;
    logic [TW-1:0]   disp_rob_entry;
    logic [2:0]      disp_logical_type;
    logic [4:0]      disp_opcode;
    logic            disp_add_info;
    logic            disp_rs1_rdy;
    logic [TW-1:0]   disp_rs1_tag;
    logic [XLEN-1:0] disp_rs1_val;
    logic            disp_rs2_rdy;
    logic [TW-1:0]   disp_rs2_tag;
    logic [XLEN-1:0] disp_rs2_val;

    logic            cdb_valid;
    logic [TW-1:0]   cdb_rob_entry;
    logic [XLEN-1:0] cdb_result;

    logic            iss_valid;
    logic [TW-1:0]   iss_rob_entry;
    logic [2:0]      iss_logical_type;
    logic [4:0]      iss_opcode;
    logic            iss_add_info;
    logic [XLEN-1:0] iss_rs1;
    logic [XLEN-1:0] iss_rs2;

    modport master (
        output flush,
        output disp_valid, disp_rob_entry, disp_logical_type, disp_opcode, disp_add_info,
        output disp_rs1_rdy, disp_rs1_tag, disp_rs1_val,
        output disp_rs2_rdy, disp_rs2_tag, disp_rs2_val,
        output cdb_valid, cdb_rob_entry, cdb_result,
        input  disp_ready,
        input  iss_valid, iss_rob_entry, iss_logical_type, iss_opcode, iss_add_info,
        input  iss_rs1, iss_rs2
    );

    modport slave (
        input  flush,
        input  disp_valid, disp_rob_entry, disp_logical_type, disp_opcode, disp_add_info,
        input  disp_rs1_rdy, disp_rs1_tag, disp_rs1_val,
        input  disp_rs2_rdy, disp_rs2_tag, disp_rs2_val,
        input  cdb_valid, cdb_rob_entry, cdb_result,
        output disp_ready,
        output iss_valid, iss_rob_entry, iss_logical_type, iss_opcode, iss_add_info,
        output iss_rs1, iss_rs2
    );
endinterface

// File: rtl/logical_rs.sv
// Reservation station for the logical/shift FU: compacting oldest-first queue, CDB wakeup,
// one registered issue per cycle. Define LOGICAL_RS_PERF_EN to add stall/issue counters.
module logical_rs #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ROB_SIZE = 256,
    parameter int unsigned RS_DEPTH = 8
) (
    input logic         clk,
    input logic         rst,
    logical_rs_if.slave rs
`ifdef LOGICAL_RS_PERF_EN
    ,
    output logic [31:0] perf_full_stall,
    output logic [31:0] perf_issued
`endif
);
    localparam int unsigned TW = $clog2(ROB_SIZE);
    localparam int unsigned IW = $clog2(RS_DEPTH);
    localparam int unsigned CW = $clog2(RS_DEPTH + 1);

    typedef struct packed {
        logic [TW-1:0]   rob;
        logic [2:0]      ltype;
        logic [4:0]      opcode;
        logic            add_info;
        logic            rs1_rdy;
        logic [TW-1:0]   rs1_tag;
        logic [XLEN-1:0] rs1_val;
        logic            rs2_rdy;
        logic [TW-1:0]   rs2_tag;
        logic [XLEN-1:0] rs2_val;
    } entry_t;

    entry_t                ent_q [RS_DEPTH];
    entry_t                ent_d [RS_DEPTH];
    logic [RS_DEPTH-1:0]   valid_q, valid_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  iss_valid_q, iss_valid_d;
    logic [TW-1:0]         iss_rob_q, iss_rob_d;
    logic [2:0]            iss_ltype_q, iss_ltype_d;
    logic [4:0]            iss_opcode_q, iss_opcode_d;
    logic                  iss_add_q, iss_add_d;
    logic [XLEN-1:0]       iss_rs1_q, iss_rs1_d;
    logic [XLEN-1:0]       iss_rs2_q, iss_rs2_d;

    logic                  disp_ready;
    logic                  do_disp;
    logic                  do_issue;
    logic [IW-1:0]         sel_idx;
    logic [CW-1:0]         tail;
    entry_t                new_ent;

    function automatic entry_t wake(entry_t e, logic cv, logic [TW-1:0] ct,
                                    logic [XLEN-1:0] cr);
        entry_t w;
        w = e;
        if (cv && !e.rs1_rdy && e.rs1_tag == ct) begin
            w.rs1_rdy = 1'b1;
            w.rs1_val = cr;
        end
        if (cv && !e.rs2_rdy && e.rs2_tag == ct) begin
            w.rs2_rdy = 1'b1;
            w.rs2_val = cr;
        end
        return w;
    endfunction

    // Credit comes from the registered count only; a same-cycle issue does not free a slot.
    assign disp_ready = (count_q < CW'(RS_DEPTH));
    assign do_disp    = rs.disp_valid && disp_ready;

    // Oldest-first select over registered ready bits only.
    always_comb begin
        do_issue = 1'b0;
        sel_idx  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!do_issue && valid_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                do_issue = 1'b1;
                sel_idx  = IW'(i);
            end
        end
    end

    // Incoming op, with the CDB bypassed into any source it is still waiting on.
    always_comb begin
        new_ent.rob      = rs.disp_rob_entry;
        new_ent.ltype    = rs.disp_logical_type;
        new_ent.opcode   = rs.disp_opcode;
        new_ent.add_info = rs.disp_add_info;
        new_ent.rs1_rdy  = rs.disp_rs1_rdy;
        new_ent.rs1_tag  = rs.disp_rs1_tag;
        new_ent.rs1_val  = rs.disp_rs1_val;
        new_ent.rs2_rdy  = rs.disp_rs2_rdy;
        new_ent.rs2_tag  = rs.disp_rs2_tag;
        new_ent.rs2_val  = rs.disp_rs2_val;
        new_ent          = wake(new_ent, rs.cdb_valid, rs.cdb_rob_entry, rs.cdb_result);
    end

    always_comb begin
        tail    = count_q - CW'(do_issue);
        count_d = count_q + CW'(do_disp) - CW'(do_issue);
        for (int i = 0; i < RS_DEPTH; i++) begin
            int src;
            src = i;
            if (do_issue && i >= int'(sel_idx)) begin
                src = (i + 1 < RS_DEPTH) ? i + 1 : i;
            end
            ent_d[i]   = wake(ent_q[src], rs.cdb_valid, rs.cdb_rob_entry, rs.cdb_result);
            valid_d[i] = valid_q[src];
            if (do_issue && i == RS_DEPTH - 1) begin
                valid_d[i] = 1'b0;
            end
            if (do_disp && CW'(i) == tail) begin
                ent_d[i]   = new_ent;
                valid_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        iss_valid_d  = do_issue;
        iss_rob_d    = iss_rob_q;
        iss_ltype_d  = iss_ltype_q;
        iss_opcode_d = iss_opcode_q;
        iss_add_d    = iss_add_q;
        iss_rs1_d    = iss_rs1_q;
        iss_rs2_d    = iss_rs2_q;
        if (do_issue) begin
            iss_rob_d    = ent_q[sel_idx].rob;
            iss_ltype_d  = ent_q[sel_idx].ltype;
            iss_opcode_d = ent_q[sel_idx].opcode;
            iss_add_d    = ent_q[sel_idx].add_info;
            iss_rs1_d    = ent_q[sel_idx].rs1_val;
            iss_rs2_d    = ent_q[sel_idx].rs2_val;
        end
    end

    // Flush wins over any same-cycle dispatch or issue.
    always_ff @(posedge clk) begin
        if (rst || rs.flush) begin
            valid_q      <= '0;
            count_q      <= '0;
            iss_valid_q  <= 1'b0;
            iss_rob_q    <= '0;
            iss_ltype_q  <= '0;
            iss_opcode_q <= '0;
            iss_add_q    <= 1'b0;
            iss_rs1_q    <= '0;
            iss_rs2_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            count_q      <= count_d;
            iss_valid_q  <= iss_valid_d;
            iss_rob_q    <= iss_rob_d;
            iss_ltype_q  <= iss_ltype_d;
            iss_opcode_q <= iss_opcode_d;
            iss_add_q    <= iss_add_d;
            iss_rs1_q    <= iss_rs1_d;
            iss_rs2_q    <= iss_rs2_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    assign rs.disp_ready       = disp_ready;
    assign rs.iss_valid        = iss_valid_q;
    assign rs.iss_rob_entry    = iss_rob_q;
    assign rs.iss_logical_type = iss_ltype_q;
    assign rs.iss_opcode       = iss_opcode_q;
    assign rs.iss_add_info     = iss_add_q;
    assign rs.iss_rs1          = iss_rs1_q;
    assign rs.iss_rs2          = iss_rs2_q;

`ifdef LOGICAL_RS_PERF_EN
    logic [31:0] perf_full_stall_q, perf_full_stall_d;
    logic [31:0] perf_issued_q, perf_issued_d;

    always_comb begin
        perf_full_stall_d = perf_full_stall_q
                          + ((rs.disp_valid && !disp_ready) ? 32'd1 : 32'd0);
        perf_issued_d     = perf_issued_q + ((do_issue && !rs.flush) ? 32'd1 : 32'd0);
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_stall_q <= '0;
            perf_issued_q     <= '0;
        end else begin
            perf_full_stall_q <= perf_full_stall_d;
            perf_issued_q     <= perf_issued_d;
        end
    end

    assign perf_full_stall = perf_full_stall_q;
    assign perf_issued     = perf_issued_q;
`endif
endmodule

// File: tb/tb_logical_rs.sv
// Scoreboarded bench for logical_rs: expected issues are queued at stimulus time and
// popped by a negedge monitor; each scenario task also checks issue timing inline.
module tb_logical_rs;
    localparam int unsigned XLEN = 32;
    localparam int unsigned TW   = 8;

    typedef struct packed {
        logic [TW-1:0]   rob;
        logic [2:0]      ltype;
        logic [4:0]      opc;
        logic            add;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    exp_t exp_q[$];
    exp_t mon_e;

    logical_rs_if #(.XLEN(XLEN), .TW(TW)) bus ();

`ifdef LOGICAL_RS_PERF_EN
    logic [31:0] perf_full_stall;
    logic [31:0] perf_issued;
`endif

    logical_rs #(.XLEN(XLEN), .ROB_SIZE(256), .RS_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (bus)
`ifdef LOGICAL_RS_PERF_EN
        ,
        .perf_full_stall (perf_full_stall),
        .perf_issued     (perf_issued)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every issued op must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.iss_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_issue got rob=%0d want no issue", bus.iss_rob_entry);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.iss_rob_entry, bus.iss_logical_type, bus.iss_opcode, bus.iss_add_info,
                     bus.iss_rs1, bus.iss_rs2} !== mon_e) begin
                    n_miss++;
                    $display("FAIL issue_fields got rob=%0d t=%0d op=%0d a=%0b rs1=%h rs2=%h want rob=%0d t=%0d op=%0d a=%0b rs1=%h rs2=%h",
                             bus.iss_rob_entry, bus.iss_logical_type, bus.iss_opcode,
                             bus.iss_add_info, bus.iss_rs1, bus.iss_rs2, mon_e.rob, mon_e.ltype,
                             mon_e.opc, mon_e.add, mon_e.rs1, mon_e.rs2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
    endtask

    task automatic drive_disp(input logic [TW-1:0] tag, input logic [2:0] lt,
                              input logic [4:0] opc, input logic add,
                              input logic r1rdy, input logic [TW-1:0] r1tag,
                              input logic [XLEN-1:0] r1val,
                              input logic r2rdy, input logic [TW-1:0] r2tag,
                              input logic [XLEN-1:0] r2val);
        bus.disp_valid        = 1'b1;
        bus.disp_rob_entry    = tag;
        bus.disp_logical_type = lt;
        bus.disp_opcode       = opc;
        bus.disp_add_info     = add;
        bus.disp_rs1_rdy      = r1rdy;
        bus.disp_rs1_tag      = r1tag;
        bus.disp_rs1_val      = r1val;
        bus.disp_rs2_rdy      = r2rdy;
        bus.disp_rs2_tag      = r2tag;
        bus.disp_rs2_val      = r2val;
    endtask

    task automatic drive_cdb(input logic [TW-1:0] tag, input logic [XLEN-1:0] val);
        bus.cdb_valid     = 1'b1;
        bus.cdb_rob_entry = tag;
        bus.cdb_result    = val;
    endtask

    task automatic test_reset();
        idle();
        drive_disp(8'd0, 3'd0, 5'd0, 1'b0, 1'b1, 8'd0, '0, 1'b1, 8'd0, '0);
        bus.disp_valid = 1'b0;
        drive_cdb(8'd0, '0);
        bus.cdb_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if ({bus.iss_valid, bus.iss_rob_entry, bus.iss_logical_type, bus.iss_opcode,
             bus.iss_add_info, bus.iss_rs1, bus.iss_rs2} !== '0) begin
            n_miss++;
            $display("FAIL reset_iss got valid=%0b rob=%0d rs1=%h rs2=%h want all 0",
                     bus.iss_valid, bus.iss_rob_entry, bus.iss_rs1, bus.iss_rs2);
        end
        n_vec++;
        if (bus.disp_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_disp_ready got %0b want 1", bus.disp_ready);
        end
`ifdef LOGICAL_RS_PERF_EN
        n_vec++;
        if (perf_full_stall !== 32'd0 || perf_issued !== 32'd0) begin
            n_miss++;
            $display("FAIL reset_perf got stall=%0d issued=%0d want 0 0",
                     perf_full_stall, perf_issued);
        end
`endif
    endtask

    task automatic test_ready_issue();
        drive_disp(8'd5, 3'b100, 5'b01100, 1'b0, 1'b1, 8'd0, 32'hF0F0, 1'b1, 8'd0, 32'h0FF0);
        exp_q.push_back('{8'd5, 3'b100, 5'b01100, 1'b0, 32'hF0F0, 32'h0FF0});
        tick();
        idle();
        n_vec++;
        if (bus.iss_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL ready_too_early got iss_valid=%0b want 0", bus.iss_valid);
        end
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rob_entry !== 8'd5) begin
            n_miss++;
            $display("FAIL ready_issue got valid=%0b rob=%0d want 1 5",
                     bus.iss_valid, bus.iss_rob_entry);
        end
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b0 || bus.iss_rob_entry !== 8'd5) begin
            n_miss++;
            $display("FAIL ready_hold got valid=%0b rob=%0d want 0 5",
                     bus.iss_valid, bus.iss_rob_entry);
        end
    endtask

    task automatic test_cdb_wakeup();
        drive_disp(8'd7, 3'b110, 5'b01100, 1'b0, 1'b1, 8'd0, 32'h55, 1'b0, 8'd3, 32'hDEAD);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (bus.iss_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL wake_waiting cycle %0d got iss_valid=%0b want 0", i, bus.iss_valid);
            end
        end
        drive_cdb(8'd3, 32'h1234);
        exp_q.push_back('{8'd7, 3'b110, 5'b01100, 1'b0, 32'h55, 32'h1234});
        tick();
        idle();
        n_vec++;
        if (bus.iss_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL wake_same_edge got iss_valid=%0b want 0", bus.iss_valid);
        end
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rs2 !== 32'h1234) begin
            n_miss++;
            $display("FAIL wake_issue got valid=%0b rs2=%h want 1 00001234",
                     bus.iss_valid, bus.iss_rs2);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive_disp(8'd11, 3'b111, 5'b01100, 1'b0, 1'b0, 8'd9, 32'h0, 1'b1, 8'd0, 32'h3C);
        drive_cdb(8'd9, 32'hAA);
        exp_q.push_back('{8'd11, 3'b111, 5'b01100, 1'b0, 32'hAA, 32'h3C});
        tick();
        idle();
        n_vec++;
        if (bus.iss_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL bypass_early got iss_valid=%0b want 0", bus.iss_valid);
        end
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rs1 !== 32'hAA) begin
            n_miss++;
            $display("FAIL bypass_issue got valid=%0b rs1=%h want 1 000000aa",
                     bus.iss_valid, bus.iss_rs1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_disp(8'd41, 3'b001, 5'b01100, 1'b0, 1'b1, 8'd0, 32'h1, 1'b1, 8'd0, 32'h4);
        exp_q.push_back('{8'd41, 3'b001, 5'b01100, 1'b0, 32'h1, 32'h4});
        tick();
        drive_disp(8'd42, 3'b101, 5'b00100, 1'b1, 1'b1, 8'd0, 32'h8000_0000, 1'b1, 8'd0, 32'h3);
        exp_q.push_back('{8'd42, 3'b101, 5'b00100, 1'b1, 32'h8000_0000, 32'h3});
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rob_entry !== 8'd41) begin
            n_miss++;
            $display("FAIL b2b_first got valid=%0b rob=%0d want 1 41", bus.iss_valid, bus.iss_rob_entry);
        end
        drive_disp(8'd43, 3'b000, 5'b01101, 1'b0, 1'b1, 8'd0, 32'hCAFE, 1'b1, 8'd0, 32'h0);
        exp_q.push_back('{8'd43, 3'b000, 5'b01101, 1'b0, 32'hCAFE, 32'h0});
        tick();
        idle();
        n_vec++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rob_entry !== 8'd42) begin
            n_miss++;
            $display("FAIL b2b_second got valid=%0b rob=%0d want 1 42", bus.iss_valid, bus.iss_rob_entry);
        end
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rob_entry !== 8'd43) begin
            n_miss++;
            $display("FAIL b2b_third got valid=%0b rob=%0d want 1 43", bus.iss_valid, bus.iss_rob_entry);
        end
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_drain got iss_valid=%0b want 0", bus.iss_valid);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            drive_disp(TW'(10 + i), 3'b100, 5'b01100, 1'b0, 1'b0,
                       (i == 2 || i == 5) ? 8'd40 : TW'(50 + i), 32'h0,
                       1'b1, 8'd0, XLEN'(32'h100 + i));
            tick();
        end
        idle();
        n_vec++;
        if (bus.disp_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL full_disp_ready got %0b want 0", bus.disp_ready);
        end
        // A ready op offered while full must be dropped, including in the issue cycle.
        drive_disp(8'd99, 3'b100, 5'b01100, 1'b0, 1'b1, 8'd0, 32'h9, 1'b1, 8'd0, 32'h9);
        drive_cdb(8'd40, 32'hBEEF);
        exp_q.push_back('{8'd12, 3'b100, 5'b01100, 1'b0, 32'hBEEF, 32'h102});
        exp_q.push_back('{8'd15, 3'b100, 5'b01100, 1'b0, 32'hBEEF, 32'h105});
        tick();
        bus.cdb_valid = 1'b0;
        n_vec++;
        if (bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL full_wake_edge got valid=%0b ready=%0b want 0 0",
                     bus.iss_valid, bus.disp_ready);
        end
        tick();
        idle();
        n_vec++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rob_entry !== 8'd12 || bus.disp_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL full_first got valid=%0b rob=%0d ready=%0b want 1 12 1",
                     bus.iss_valid, bus.iss_rob_entry, bus.disp_ready);
        end
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rob_entry !== 8'd15) begin
            n_miss++;
            $display("FAIL full_second got valid=%0b rob=%0d want 1 15",
                     bus.iss_valid, bus.iss_rob_entry);
        end
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL full_dropped got iss_valid=%0b want 0", bus.iss_valid);
        end
        bus.flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            drive_disp(TW'(20 + i), 3'b110, 5'b01100, 1'b0, 1'b0, 8'd60, 32'h0, 1'b1, 8'd0, 32'h1);
            tick();
        end
        drive_disp(8'd30, 3'b110, 5'b01100, 1'b0, 1'b1, 8'd0, 32'h7, 1'b1, 8'd0, 32'h7);
        bus.flush = 1'b1;
        tick();
        idle();
        n_vec++;
        if (bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b1 || bus.iss_rob_entry !== 8'd0) begin
            n_miss++;
            $display("FAIL flush_state got valid=%0b ready=%0b rob=%0d want 0 1 0",
                     bus.iss_valid, bus.disp_ready, bus.iss_rob_entry);
        end
        drive_cdb(8'd60, 32'h66);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (bus.iss_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL flush_ghost cycle %0d got iss_valid=%0b want 0", i, bus.iss_valid);
            end
        end
        drive_disp(8'd31, 3'b111, 5'b01100, 1'b0, 1'b1, 8'd0, 32'h12, 1'b1, 8'd0, 32'h34);
        exp_q.push_back('{8'd31, 3'b111, 5'b01100, 1'b0, 32'h12, 32'h34});
        tick();
        idle();
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rob_entry !== 8'd31) begin
            n_miss++;
            $display("FAIL flush_recover got valid=%0b rob=%0d want 1 31",
                     bus.iss_valid, bus.iss_rob_entry);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive_disp(8'd33, 3'b100, 5'b01100, 1'b0, 1'b1, 8'd0, 32'h5, 1'b1, 8'd0, 32'h6);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (bus.iss_valid !== 1'b0 || bus.iss_rob_entry !== 8'd0 || bus.iss_rs1 !== 32'd0) begin
            n_miss++;
            $display("FAIL reset_mid got valid=%0b rob=%0d rs1=%h want 0 0 0",
                     bus.iss_valid, bus.iss_rob_entry, bus.iss_rs1);
        end
        tick();
        n_vec++;
        if (bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_mid_after got valid=%0b ready=%0b want 0 1",
                     bus.iss_valid, bus.disp_ready);
        end
    endtask

`ifdef LOGICAL_RS_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_disp(TW'(80 + i), 3'b001, 5'b01100, 1'b0, 1'b0,
                       (i < 3) ? 8'd70 : 8'd71, 32'h0, 1'b1, 8'd0, XLEN'(i));
            tick();
        end
        drive_disp(8'd88, 3'b001, 5'b01100, 1'b0, 1'b1, 8'd0, 32'h0, 1'b1, 8'd0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        idle();
        n_vec++;
        if (perf_full_stall !== 32'd4) begin
            n_miss++;
            $display("FAIL perf_stall got %0d want 4", perf_full_stall);
        end
        drive_cdb(8'd70, 32'h77);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{TW'(80 + i), 3'b001, 5'b01100, 1'b0, 32'h77, XLEN'(i)});
        end
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (perf_issued !== 32'd3) begin
            n_miss++;
            $display("FAIL perf_issued got %0d want 3", perf_issued);
        end
        bus.flush = 1'b1;
        tick();
        idle();
        tick();
        n_vec++;
        if (perf_full_stall !== 32'd4 || perf_issued !== 32'd3) begin
            n_miss++;
            $display("FAIL perf_after_flush got stall=%0d issued=%0d want 4 3",
                     perf_full_stall, perf_issued);
        end
    endtask
`endif

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        test_reset();
        test_ready_issue();
        test_cdb_wakeup();
        test_bypass();
        test_back_to_back();
        test_full();
        test_flush();
        test_reset_mid();
`ifdef LOGICAL_RS_PERF_EN
        test_perf();
`endif
        tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
